// File: rtl/uio_bus_responder.sv
// uio_bus_responder: byte-wide four-register responder on the Tiny Tapeout pins.
// The host runs a 4-phase req/ack handshake on ui_in; reads are driven onto
// uio_out with uio_oe = 0xFF, and the bus is released after a turnaround cycle.
// Optional feature macro: UIO_RESP_TIMEOUT_EN (abort a stuck ACK after
// TIMEOUT_CYCLES cycles and raise a sticky error flag on uo_out[2]).
module uio_bus_responder #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CAPTURE    = 2'd1,
    ACK        = 2'd2,
    TURNAROUND = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        s1_reg, s2_reg, s3_reg;
  logic        rise;
  logic [1:0]  addr_reg;
  logic        we_reg;
  logic [7:0]  data_reg;
  logic [7:0]  regs [4];
  logic [3:0]  wr_sel;
  logic [7:0]  uio_out_reg, uio_oe_reg;
  logic        ack_reg;
  logic [4:0]  count_reg;
  logic        err_reg;
  logic        tmo_hit;
  logic        busy;
  logic        unused_ui;

  // Upper ui_in bits carry nothing for this block.
  assign unused_ui = ^ui_in[7:4];

  // Synchronise req; flops preset to 1 so a req held through reset never looks like a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
      s3_reg <= 1'b1;
    end else begin
      s1_reg <= ui_in[0];
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic for the handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (rise) state_next = CAPTURE;
      CAPTURE:    state_next = ACK;
      ACK:        if (!s2_reg) state_next = we_reg ? IDLE : TURNAROUND;
      TURNAROUND: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // One write strobe per register, active in CAPTURE for a write to that address.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
    assign wr_sel[gi] = (state_reg == CAPTURE) && we_reg && (addr_reg == 2'(gi));
  end

  // Register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) regs[i] <= data_reg;
      end
    end
  end

  // Request latch, read-data drive, ack and transaction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      data_reg    <= '0;
      uio_out_reg <= '0;
      uio_oe_reg  <= '0;
      ack_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) begin
            addr_reg <= ui_in[3:2];
            we_reg   <= ui_in[1];
            data_reg <= uio_in;
          end
        end
        CAPTURE: begin
          if (!we_reg) begin
            uio_out_reg <= regs[addr_reg];
            uio_oe_reg  <= 8'hFF;
          end
          ack_reg   <= 1'b1;
          count_reg <= count_reg + 5'd1;
        end
        ACK: begin
          if (!s2_reg || tmo_hit) ack_reg <= 1'b0;
        end
        TURNAROUND: begin
          uio_oe_reg  <= 8'h00;
          uio_out_reg <= 8'h00;
        end
        default: ;
      endcase
    end
  end

`ifdef UIO_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;

  assign tmo_hit = (state_reg == ACK) && ack_reg && s2_reg &&
                   (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent acknowledging; the error flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else if (state_reg == CAPTURE) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == ACK) && ack_reg && s2_reg) begin
      if (tmo_hit) err_reg <= 1'b1;
      else         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign err_reg    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  // Output assembly: status byte and bus drive.
  always_comb begin
    busy    = (state_reg != IDLE);
    uo_out  = {count_reg, err_reg, busy, ack_reg};
    uio_out = uio_out_reg;
    uio_oe  = uio_oe_reg;
  end

endmodule

// File: tb/tb_uio_bus_responder.sv
// Self-checking bench for uio_bus_responder: randomized host transactions,
// expected responses queued at issue time and checked by a monitor on each ack.
module tb_uio_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uio_out, uio_oe, uo_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit       we;
    bit [1:0] addr;
    bit [7:0] data;
    int       count;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] model_regs [4];
  int       model_count;

  uio_bus_responder #(.TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .uo_out (uo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    model_count = 0;
  endtask

  // Monitor: every rising ack must match the oldest queued expectation.
  exp_t mon_e;
  logic mon_prev_ack = 1'b0;
  always @(negedge clk) begin
    if (uo_out[0] === 1'b1 && mon_prev_ack === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=1, expected no transaction at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_count", 32'(uo_out[7:3]), 32'(mon_e.count));
        if (mon_e.we) begin
          chk("wr_oe", 32'(uio_oe), 32'h00);
        end else begin
          chk("rd_data", 32'(uio_out), 32'(mon_e.data));
          chk("rd_oe", 32'(uio_oe), 32'hFF);
        end
        $display("txn %s addr=%0d data=0x%02h count=%0d uio_out=0x%02h uio_oe=0x%02h",
                 mon_e.we ? "WR" : "RD", mon_e.addr, mon_e.data, mon_e.count, uio_out, uio_oe);
      end
    end
    mon_prev_ack = uo_out[0];
  end

  // Issue a request, queue its expected result, wait for ack and check its latency.
  task automatic raise_and_wait(input bit we, input bit [1:0] addr, input bit [7:0] data);
    exp_t e;
    int i;
    if (we) model_regs[addr] = data;
    model_count = (model_count + 1) % 32;
    e.we = we;
    e.addr = addr;
    e.data = we ? data : model_regs[addr];
    e.count = model_count;
    exp_q.push_back(e);
    @(negedge clk);
    ui_in  = {4'($urandom), addr, we, 1'b1};
    uio_in = we ? data : 8'($urandom);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (uo_out[0] !== 1'b1 && i < 50);
    chk("ack_seen", 32'(uo_out[0]), 32'd1);
    chk("ack_latency", 32'(i), 32'd4);
  endtask

  // Drop req and check ack release timing and bus turnaround.
  task automatic release_req(input bit we);
    int i;
    ui_in[0] = 1'b0;
    i = 0;
    do begin
      @(negedge clk);
      i++;
      if (we) chk("wr_oe_idle", 32'(uio_oe), 32'h00);
    end while (uo_out[0] !== 1'b0 && i < 50);
    chk("ack_release", 32'(i), 32'd3);
    if (!we) begin
      chk("ta_oe_hold", 32'(uio_oe), 32'hFF);
      @(negedge clk);
      chk("ta_oe_off", 32'(uio_oe), 32'h00);
      chk("ta_out_off", 32'(uio_out), 32'h00);
    end
    chk("idle_busy", 32'(uo_out[1]), 32'd0);
  endtask

  task automatic do_txn(input bit we, input bit [1:0] addr, input bit [7:0] data);
    raise_and_wait(we, addr, data);
    release_req(we);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_uo_out", 32'(uo_out), 32'h00);
    chk("rst_uio_out", 32'(uio_out), 32'h00);
    chk("rst_uio_oe", 32'(uio_oe), 32'h00);

    // Basic write / read-back / read of untouched register.
    do_txn(1'b1, 2'd2, 8'hA5);
    do_txn(1'b0, 2'd2, 8'h00);
    do_txn(1'b0, 2'd0, 8'h00);

    // req held high through reset must not start a transaction.
    rst = 1'b1;
    ui_in = 8'h01;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("held_req_ack", 32'(uo_out[0]), 32'd0);
      chk("held_req_busy", 32'(uo_out[1]), 32'd0);
    end
    ui_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    do_txn(1'b1, 2'd1, 8'h5A);

    // Reset during ACK of a read.
    raise_and_wait(1'b0, 2'd1, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_uo_out", 32'(uo_out), 32'h00);
    chk("midrst_uio_oe", 32'(uio_oe), 32'h00);
    chk("midrst_uio_out", 32'(uio_out), 32'h00);
    ui_in[0] = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 4; a++) do_txn(1'b0, 2'(a), 8'h00);

    // Count wrap: fresh reset, then 33 writes leaves count at 1.
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 33; k++) do_txn(1'b1, 2'(k % 4), 8'($urandom));
    chk("wrap_count", 32'(uo_out[7:3]), 32'd1);

    // Distinct patterns per address.
    do_txn(1'b1, 2'd0, 8'h11);
    do_txn(1'b1, 2'd1, 8'h22);
    do_txn(1'b1, 2'd2, 8'h33);
    do_txn(1'b1, 2'd3, 8'h44);
    for (int a = 3; a >= 0; a--) do_txn(1'b0, 2'(a), 8'h00);

    // Randomized traffic with random idle gaps.
    for (int k = 0; k < 40; k++) begin
      do_txn(1'($urandom), 2'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef UIO_RESP_TIMEOUT_EN
    raise_and_wait(1'b1, 2'd3, 8'h77);
    i = 0;
    while (uo_out[0] === 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("tmo_ack_drop", 32'(uo_out[0]), 32'd0);
    chk("tmo_err", 32'(uo_out[2]), 32'd1);
    chk("tmo_busy_held", 32'(uo_out[1]), 32'd1);
    ui_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("tmo_idle", 32'(uo_out[1]), 32'd0);
    do_txn(1'b0, 2'd3, 8'h00);
    do_txn(1'b1, 2'd0, 8'hC3);
    chk("tmo_err_sticky", 32'(uo_out[2]), 32'd1);
`else
    raise_and_wait(1'b1, 2'd3, 8'h77);
    i = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (uo_out[0] !== 1'b1) i++;
    end
    chk("no_tmo_ack_drops", 32'(i), 32'd0);
    chk("no_tmo_err", 32'(uo_out[2]), 32'd0);
    release_req(1'b1);
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
